text_mem_resp: RTL

TEXT_MEM_RESP -- requirements
Module: text_mem_resp

---
 rtl/text_mem_resp.sv | 107 ++++++++++
 1 files changed

// File: rtl/text_mem_resp.sv
// Instruction text memory: program-load write port plus a request/ack fetch read port.
// Optional sticky write protection is compiled in with `define TEXT_MEM_WPROT_EN.
module text_mem_resp #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [5:0]  rd_addr,
    output logic        rd_ack,
    output logic [31:0] rd_data,
    input  logic        ld_valid,
    input  logic [5:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        lock,
    output logic [6:0]  ld_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [6:0] DEPTH_W   = 7'(DEPTH);
    localparam logic [6:0] COUNT_MAX = 7'd64;

    state_t      state;
    state_t      next_state;
    logic        wprot;
    logic        ld_fire;
    logic        mem_we;
    logic        rd_accept;
    logic [31:0] read_word;
    logic [31:0] mem [DEPTH];

`ifdef TEXT_MEM_WPROT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wprot <= 1'b0;
        else if (lock)
            wprot <= 1'b1;
    end
`else
    logic unused_lock;
    assign unused_lock = lock;
    assign wprot       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // A pending load always takes the IDLE slot ahead of a read.
    always_comb begin
        next_state = state;
        ld_ready   = 1'b0;
        rd_ack     = 1'b0;
        rd_accept  = 1'b0;
        case (state)
            IDLE: begin
                ld_ready  = ~wprot;
                rd_accept = rd_req & ~(ld_valid & ~wprot);
                if (rd_accept)
                    next_state = RESP;
            end
            RESP: begin
                rd_ack     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign ld_fire = ld_valid & ld_ready;
    // Reset holds ld_ready high, so the write enable must be masked by reset itself.
    assign mem_we  = ld_fire & ~rst & ({1'b0, ld_addr} < DEPTH_W);

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[ld_addr] <= ld_data;
    end

    always_comb begin
        read_word = 32'h0;
        if ({1'b0, rd_addr} < DEPTH_W)
            read_word = mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= 32'h0;
        else if (rd_accept)
            rd_data <= read_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ld_count <= 7'd0;
        else if (ld_fire && ld_count != COUNT_MAX)
            ld_count <= ld_count + 7'd1;
    end

endmodule
